mbist_march_ctrl: RTL and testbench



---
 rtl/mbist_pkg.sv | 71 +++++++
 rtl/mbist_checker.sv | 108 ++++++++++
 rtl/mbist_march_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_mbist_march_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mbist_pkg.sv
// ---------------------------------------------------------------------------
// mbist_pkg
// Shared types and constant tables for the March C- MBIST controller.
//   - op_t    : per-cycle memory operation issued to the SRAM
//   - state_t : controller FSM state
//   - elem_t  : March element index (0..NUM_ELEM-1)
//   - helper functions describing each March C- element: sweep direction,
//     number of ops per address, and the op code for a given op slot.
// ---------------------------------------------------------------------------
package mbist_pkg;

    typedef enum logic [2:0] {
        OP_W0,
        OP_W1,
        OP_R0,
        OP_R1,
        OP_NONE
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam int NUM_ELEM = 6;

    typedef logic [2:0] elem_t;

    localparam elem_t LAST_ELEM = elem_t'(NUM_ELEM - 1);

    // March C-:  up(w0) up(r0,w1) up(r1,w0) down(r0,w1) down(r1,w0) up(r0)
    function automatic logic elem_is_down(input elem_t elem);
        logic down;
        unique case (elem)
            3'd3, 3'd4: down = 1'b1;
            default:    down = 1'b0;
        endcase
        return down;
    endfunction

    function automatic logic [1:0] elem_nops(input elem_t elem);
        logic [1:0] nops;
        unique case (elem)
            3'd0, 3'd5: nops = 2'd1;
            default:    nops = 2'd2;
        endcase
        return nops;
    endfunction

    // True when op slot idx is the final op applied at one address.
    function automatic logic elem_last_op(input elem_t elem, input logic idx);
        return (elem_nops(elem) == 2'd1) || idx;
    endfunction

    function automatic op_t elem_op(input elem_t elem, input logic idx);
        op_t op;
        unique case (elem)
            3'd0:    op = OP_W0;
            3'd1:    op = idx ? OP_W1 : OP_R0;
            3'd2:    op = idx ? OP_W0 : OP_R1;
            3'd3:    op = idx ? OP_W1 : OP_R0;
            3'd4:    op = idx ? OP_W0 : OP_R1;
            3'd5:    op = OP_R0;
            default: op = OP_NONE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/mbist_checker.sv
// ---------------------------------------------------------------------------
// mbist_checker
// Read-compare pipeline for the March controller. Each issued read carries
// {valid, addr, elem, expected} down an RD_LAT-deep shift so that it lines
// up with the SRAM data returning on mem_dout RD_LAT cycles later.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   clr                 synchronous clear of results (new run accepted)
//   iss_vld             a read is issued this cycle
//   iss_addr/elem/exp   address, March element and expected data of it
//   mem_dout            SRAM read data
//   fail                sticky mismatch flag for the current run
//   fail_count          saturating count of mismatching reads
//   fail_addr/elem      location of the first mismatch
//   fail_exp/act        expected and actual data of the first mismatch
// ---------------------------------------------------------------------------
module mbist_checker
    import mbist_pkg::*;
#(
    parameter int AW     = 8,
    parameter int WLEN   = 4,
    parameter int RD_LAT = 2,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             iss_vld,
    input  logic [AW-1:0]    iss_addr,
    input  elem_t            iss_elem,
    input  logic [WLEN-1:0]  iss_exp,
    input  logic [WLEN-1:0]  mem_dout,
    output logic             fail,
    output logic [CNT_W-1:0] fail_count,
    output logic [AW-1:0]    fail_addr,
    output elem_t            fail_elem,
    output logic [WLEN-1:0]  fail_exp,
    output logic [WLEN-1:0]  fail_act
);

    logic [RD_LAT-1:0] pipe_vld;
    logic [AW-1:0]     pipe_addr [RD_LAT];
    elem_t             pipe_elem [RD_LAT];
    logic [WLEN-1:0]   pipe_exp  [RD_LAT];

    logic              chk_vld;
    logic              mismatch;

    // Valid bits carry control meaning and are cleared by reset; the payload
    // is only ever looked at alongside its valid, so it needs no reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld <= '0;
        end else begin
            pipe_vld[0] <= iss_vld;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        pipe_addr[0] <= iss_addr;
        pipe_elem[0] <= iss_elem;
        pipe_exp[0]  <= iss_exp;
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_addr[i] <= pipe_addr[i-1];
            pipe_elem[i] <= pipe_elem[i-1];
            pipe_exp[i]  <= pipe_exp[i-1];
        end
    end

    assign chk_vld  = pipe_vld[RD_LAT-1];
    assign mismatch = chk_vld && (mem_dout != pipe_exp[RD_LAT-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail       <= 1'b0;
            fail_count <= '0;
            fail_addr  <= '0;
            fail_elem  <= '0;
            fail_exp   <= '0;
            fail_act   <= '0;
        end else if (clr) begin
            fail       <= 1'b0;
            fail_count <= '0;
            fail_addr  <= '0;
            fail_elem  <= '0;
            fail_exp   <= '0;
            fail_act   <= '0;
        end else if (mismatch) begin
            fail <= 1'b1;
            if (fail_count != '1) begin
                fail_count <= fail_count + CNT_W'(1);
            end
            // Only the first mismatch of a run is recorded; fail is still
            // low during that cycle.
            if (!fail) begin
                fail_addr <= pipe_addr[RD_LAT-1];
                fail_elem <= pipe_elem[RD_LAT-1];
                fail_exp  <= pipe_exp[RD_LAT-1];
                fail_act  <= mem_dout;
            end
        end
    end

endmodule

// File: rtl/mbist_march_ctrl.sv
// ---------------------------------------------------------------------------
// mbist_march_ctrl
// March C- MBIST initiator for a WCOUNT x WLEN single-port SRAM. Issues one
// memory op per cycle with no bubbles, compares read data through a
// latency-matched pipeline and reports pass/fail plus first-failure details.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start           one-cycle pulse; starts a run from IDLE or DONE
//   busy            run or drain in progress
//   done            run complete, results valid until next start
//   fail            sticky mismatch flag
//   fail_count      saturating mismatch count
//   fail_addr/elem  first-failure address and March element
//   fail_exp/act    first-failure expected / actual data
//   mem_addr/din/we SRAM address, write data, write enable
//   mem_dout        SRAM read data
// ---------------------------------------------------------------------------
module mbist_march_ctrl
    import mbist_pkg::*;
#(
    parameter int              WCOUNT = 256,
    parameter int              WLEN   = 4,
    parameter int              RD_LAT = 2,
    parameter logic [WLEN-1:0] BG     = '0,
    parameter int              CNT_W  = 8,
    localparam int             AW     = $clog2(WCOUNT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             fail,
    output logic [CNT_W-1:0] fail_count,
    output logic [AW-1:0]    fail_addr,
    output logic [2:0]       fail_elem,
    output logic [WLEN-1:0]  fail_exp,
    output logic [WLEN-1:0]  fail_act,
    output logic [AW-1:0]    mem_addr,
    output logic [WLEN-1:0]  mem_din,
    output logic             mem_we,
    input  logic [WLEN-1:0]  mem_dout
);

    localparam int              DW       = $clog2(RD_LAT + 1) + 1;
    localparam logic [AW-1:0]   ADDR_MAX = AW'(WCOUNT - 1);

    state_t          state;
    state_t          state_next;

    elem_t           elem;
    logic [AW-1:0]   addr;
    logic            op_idx;
    logic [DW-1:0]   drain_cnt;

    op_t             op;
    logic            down;
    logic            last_op;
    logic            last_addr;
    logic            run_end;
    logic            start_ok;

    logic            iss_vld;
    logic [WLEN-1:0] iss_exp;

    // -----------------------------------------------------------------------
    // FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        op        = elem_op(elem, op_idx);
        down      = elem_is_down(elem);
        last_op   = elem_last_op(elem, op_idx);
        last_addr = down ? (addr == '0) : (addr == ADDR_MAX);
        run_end   = last_op && last_addr && (elem == LAST_ELEM);
        start_ok  = start && ((state == ST_IDLE) || (state == ST_DONE));

        state_next = state;
        unique case (state)
            ST_IDLE:  if (start)   state_next = ST_RUN;
            ST_RUN:   if (run_end) state_next = ST_DRAIN;
            ST_DRAIN: if (drain_cnt == DW'(RD_LAT)) state_next = ST_DONE;
            ST_DONE:  if (start)   state_next = ST_RUN;
            default:  state_next = ST_IDLE;
        endcase
    end

    assign busy = (state == ST_RUN) || (state == ST_DRAIN);
    assign done = (state == ST_DONE);

    // -----------------------------------------------------------------------
    // Address / op / element sequencing. Moving to the next element loads
    // that element's starting address in the same edge, so there is no
    // idle cycle between elements.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            elem      <= '0;
            addr      <= '0;
            op_idx    <= 1'b0;
            drain_cnt <= '0;
        end else if (start_ok) begin
            elem      <= '0;
            addr      <= '0;
            op_idx    <= 1'b0;
            drain_cnt <= '0;
        end else if (state == ST_RUN) begin
            if (!last_op) begin
                op_idx <= 1'b1;
            end else begin
                op_idx <= 1'b0;
                if (!last_addr) begin
                    addr <= down ? (addr - AW'(1)) : (addr + AW'(1));
                end else if (elem != LAST_ELEM) begin
                    elem <= elem + 3'd1;
                    addr <= elem_is_down(elem + 3'd1) ? ADDR_MAX : '0;
                end
            end
        end else if (state == ST_DRAIN) begin
            drain_cnt <= drain_cnt + DW'(1);
        end
    end

    // -----------------------------------------------------------------------
    // SRAM drive. Decoded from the state register so that an asynchronous
    // reset drops mem_we immediately.
    // -----------------------------------------------------------------------
    always_comb begin
        mem_addr = '0;
        mem_din  = '0;
        mem_we   = 1'b0;
        iss_vld  = 1'b0;
        iss_exp  = '0;
        if (state == ST_RUN) begin
            mem_addr = addr;
            unique case (op)
                OP_W0: begin
                    mem_we  = 1'b1;
                    mem_din = BG;
                end
                OP_W1: begin
                    mem_we  = 1'b1;
                    mem_din = ~BG;
                end
                OP_R0: begin
                    iss_vld = 1'b1;
                    iss_exp = BG;
                end
                OP_R1: begin
                    iss_vld = 1'b1;
                    iss_exp = ~BG;
                end
                default: ;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Compare pipeline and result capture
    // -----------------------------------------------------------------------
    mbist_checker #(
        .AW     (AW),
        .WLEN   (WLEN),
        .RD_LAT (RD_LAT),
        .CNT_W  (CNT_W)
    ) u_checker (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (start_ok),
        .iss_vld    (iss_vld),
        .iss_addr   (addr),
        .iss_elem   (elem),
        .iss_exp    (iss_exp),
        .mem_dout   (mem_dout),
        .fail       (fail),
        .fail_count (fail_count),
        .fail_addr  (fail_addr),
        .fail_elem  (fail_elem),
        .fail_exp   (fail_exp),
        .fail_act   (fail_act)
    );

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mbist_march_ctrl
// Directed bench for the March C- controller with a 256x4 SRAM model
// (two-stage address pipeline, registered write) and injectable faults.
// ---------------------------------------------------------------------------
module tb_mbist_march_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       busy, done, fail;
    logic [7:0] fail_count;
    logic [7:0] fail_addr;
    logic [2:0] fail_elem;
    logic [3:0] fail_exp, fail_act;
    logic [7:0] mem_addr;
    logic [3:0] mem_din;
    logic       mem_we;
    logic [3:0] mem_dout;

    int vec_cnt = 0;
    int miscompares = 0;

    // 0: none, 1: bit2 stuck-at-0 @0x37, 2: bit0 no 0->1 @0xFF,
    // 3: write of 1s to 0x10 forces bit1 of 0x11 high
    int fault = 0;

    always #5 clk = ~clk;

    mbist_march_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .fail       (fail),
        .fail_count (fail_count),
        .fail_addr  (fail_addr),
        .fail_elem  (fail_elem),
        .fail_exp   (fail_exp),
        .fail_act   (fail_act),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_we     (mem_we),
        .mem_dout   (mem_dout)
    );

    // SRAM model: addr -> a1 -> a2 read pipeline, write commits from stage 1
    logic [3:0] mem [256];
    logic [7:0] a1 = '0, a2 = '0;
    logic       we1 = 1'b0;
    logic [3:0] d1 = '0;

    function automatic logic [3:0] fault_val(input int f, input logic [7:0] a,
                                             input logic [3:0] d, input logic [3:0] old);
        logic [3:0] v;
        v = d;
        if (f == 1 && a == 8'h37) v[2] = 1'b0;
        if (f == 2 && a == 8'hFF && old[0] == 1'b0) v[0] = 1'b0;
        return v;
    endfunction

    always @(posedge clk) begin
        a1  <= mem_addr;
        we1 <= mem_we;
        d1  <= mem_din;
        a2  <= a1;
        if (we1) begin
            mem[a1] <= fault_val(fault, a1, d1, mem[a1]);
            if (fault == 3 && a1 == 8'h10 && d1 == 4'hF)
                mem[8'h11] <= mem[8'h11] | 4'h2;
        end
    end

    assign mem_dout = mem[a2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Results of one run, sampled on negedges starting in cycle 1
    int         busy_cyc, we_cyc;
    logic [7:0] first_addr, last_addr;
    logic       first_we, last_we;
    logic [3:0] first_din;
    logic       overlap, timed_out;
    logic       fail0;
    logic [7:0] cnt0;

    task automatic run_once(input int pulse_at);
        busy_cyc  = 0;
        we_cyc    = 0;
        overlap   = 1'b0;
        timed_out = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (busy) busy_cyc++;
            if (mem_we) we_cyc++;
            if (busy && done) overlap = 1'b1;
            if (i == 0) begin
                first_addr = mem_addr;
                first_we   = mem_we;
                first_din  = mem_din;
                fail0      = fail;
                cnt0       = fail_count;
            end
            if (i == 2559) begin
                last_addr = mem_addr;
                last_we   = mem_we;
            end
            start = (i == pulse_at);
            if (done) begin
                timed_out = 1'b0;
                break;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("run_timeout", 32'(timed_out), 32'd0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_fail", 32'(fail), 32'd0);
        check("rst_count", 32'(fail_count), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_done", 32'(done), 32'd0);

        // Fault-free run, with a stray start pulse mid-run
        fault = 0;
        run_once(500);
        check("ok_busy_cycles", 32'(busy_cyc), 32'd2563);
        check("ok_we_cycles", 32'(we_cyc), 32'd1280);
        check("ok_first_addr", 32'(first_addr), 32'h00);
        check("ok_first_we", 32'(first_we), 32'd1);
        check("ok_first_din", 32'(first_din), 32'h0);
        check("ok_last_addr", 32'(last_addr), 32'hFF);
        check("ok_last_we", 32'(last_we), 32'd0);
        check("ok_overlap", 32'(overlap), 32'd0);
        check("ok_done", 32'(done), 32'd1);
        check("ok_fail", 32'(fail), 32'd0);
        check("ok_count", 32'(fail_count), 32'd0);

        // Stuck-at-0, bit 2 of 0x37
        fault = 1;
        run_once(-1);
        check("saf_busy_cycles", 32'(busy_cyc), 32'd2563);
        check("saf_fail", 32'(fail), 32'd1);
        check("saf_count", 32'(fail_count), 32'd2);
        check("saf_addr", 32'(fail_addr), 32'h37);
        check("saf_elem", 32'(fail_elem), 32'd2);
        check("saf_exp", 32'(fail_exp), 32'hF);
        check("saf_act", 32'(fail_act), 32'hB);

        // Transition fault, bit 0 of 0xFF cannot rise
        fault = 2;
        run_once(-1);
        check("tf_fail", 32'(fail), 32'd1);
        check("tf_count", 32'(fail_count), 32'd2);
        check("tf_addr", 32'(fail_addr), 32'hFF);
        check("tf_elem", 32'(fail_elem), 32'd2);
        check("tf_exp", 32'(fail_exp), 32'hF);
        check("tf_act", 32'(fail_act), 32'hE);

        // Idempotent coupling 0x10 -> 0x11 bit 1
        fault = 3;
        run_once(-1);
        check("cf_fail", 32'(fail), 32'd1);
        check("cf_count", 32'(fail_count), 32'd1);
        check("cf_addr", 32'(fail_addr), 32'h11);
        check("cf_elem", 32'(fail_elem), 32'd1);
        check("cf_exp", 32'(fail_exp), 32'h0);
        check("cf_act", 32'(fail_act), 32'h2);

        // Restart from DONE with fail set: results cleared, clean rerun
        fault = 0;
        run_once(-1);
        check("rerun_fail_cleared", 32'(fail0), 32'd0);
        check("rerun_count_cleared", 32'(cnt0), 32'd0);
        check("rerun_busy_cycles", 32'(busy_cyc), 32'd2563);
        check("rerun_fail", 32'(fail), 32'd0);

        // Reset at cycle 1000 of a faulty run
        fault = 1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (999) @(negedge clk);
        check("pre_rst_fail", 32'(fail), 32'd1);
        check("pre_rst_we", 32'(mem_we), 32'd1);
        check("pre_rst_addr", 32'(mem_addr), 32'h73);
        rst_n = 1'b0;
        #1;
        check("async_rst_we", 32'(mem_we), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_fail", 32'(fail), 32'd0);
        check("async_rst_count", 32'(fail_count), 32'd0);
        check("async_rst_faddr", 32'(fail_addr), 32'd0);
        check("async_rst_addr", 32'(mem_addr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        fault = 0;
        run_once(-1);
        check("post_rst_busy_cycles", 32'(busy_cyc), 32'd2563);
        check("post_rst_done", 32'(done), 32'd1);
        check("post_rst_fail", 32'(fail), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
        $finish;
    end

endmodule
